logic_arb: RTL and testbench
============================

LOGIC_ARB -- requirements
Module: logic_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result bit width per requester.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  per-requester request, level-sensitive.
REQ-005 SHALL have port a_bus  input  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port b_bus  input  4*WIDTH  operand B, packed as a_bus.
REQ-007 SHALL have port op_bus  input  8  2-bit opcode per requester at [2i +: 2]; 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 SHALL have port lock  input  4  per-requester grant-hold request (see Configuration).
REQ-009 SHALL have port gnt  output  4  one-hot grant, high only in state GRANT.
REQ-010 SHALL have port done  output  4  one-hot completion pulse, high only in state DONE.
REQ-011 SHALL have port y  output  WIDTH  registered result of the shared logic unit.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL time-share one WIDTH-bit logic unit (AND/OR/XOR/NAND) among 4 requesters through FSM IDLE -> GRANT -> EXEC -> DONE -> IDLE.
REQ-014 In IDLE, with req nonzero, SHALL select a winner round-robin starting at rr_ptr, register it, and go to GRANT; with req zero it SHALL stay in IDLE.
REQ-015 In GRANT, SHALL assert gnt[winner] for exactly one cycle and capture the winner's A, B and op at the end of that cycle.
REQ-016 In EXEC, SHALL compute the captured op and register the result into y at the end of the cycle.
REQ-017 In DONE, SHALL assert done[winner] for one cycle; y SHALL hold its value until the next EXEC.
REQ-018 Latency: req sampled high at edge t -> gnt high during cycle t+1 -> done high during cycle t+3; throughput is one operation per 4 cycles.
REQ-019 On leaving DONE, SHALL set rr_ptr to (winner+1) mod 4; rr_ptr wraps from 3 to 0.
REQ-020 Deassertion of req[winner] after IDLE sampling SHALL NOT abort the operation; captured operands SHALL be used.
REQ-021 Operand changes after GRANT SHALL NOT affect y.
REQ-022 A req still high in the cycle after DONE SHALL be treated as a new request.
REQ-023 Simultaneous requests SHALL be served one at a time in rotation; no requester SHALL wait more than 3 operations (lock excluded).
REQ-024 gnt and done SHALL never have more than one bit set and SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rr_ptr 0, gnt 0, done 0, y 0, busy 0, and captured operands 0.
REQ-026 Reset asserted mid-operation SHALL abandon it with no done pulse; the first arbitration after release SHALL start at requester 0.

Configuration
REQ-027 Macro LOGIC_ARB_LOCK_EN defined: if lock[winner] and req[winner] are both high in DONE, the FSM SHALL go directly to GRANT for the same winner, rr_ptr SHALL NOT advance, and the hold SHALL end when either signal is low.
REQ-028 Macro LOGIC_ARB_LOCK_EN undefined: the lock port SHALL exist but be ignored, and behaviour SHALL be pure round-robin.

Verification
REQ-029 Single request: req=0001, a=8'hF0, b=8'h3C, op=00 -> gnt=0001 at t+1, done=0001 at t+3, y=8'h30.
REQ-030 All ops on requester 2 with a=8'hF0, b=8'h3C -> y = 30 (AND), FC (OR), CC (XOR), CF (NAND), each with done=0100.
REQ-031 Contention: req=1111 held -> grant order 0,1,2,3,0, each 4 cycles apart, one-hot gnt/done throughout.
REQ-032 Wrap: after serving requester 3, req=1001 -> next gnt=0001.
REQ-033 Reset during EXEC -> no done; y=0; with req=1010 after release -> first gnt=0010.
REQ-034 With LOGIC_ARB_LOCK_EN: req=0011, lock=0001 -> requester 0 granted repeatedly (DONE->GRANT); lock dropped -> next gnt=0010.

Source files
------------

// File: rtl/logic_arb.sv
// Four-requester round-robin arbiter sharing one AND/OR/XOR/NAND unit.
// Optional grant hold under macro LOGIC_ARB_LOCK_EN.
module logic_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] a_bus,
    input  logic [4*WIDTH-1:0] b_bus,
    input  logic [7:0]         op_bus,
    input  logic [3:0]         lock,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic [WIDTH-1:0]   y,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [1:0]       winner;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [1:0]       cap_op;
    logic [WIDTH-1:0] result;

`ifndef LOGIC_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // First requesting index at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + k[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        result = '0;
        unique case (cap_op)
            2'b00: result = cap_a & cap_b;
            2'b01: result = cap_a | cap_b;
            2'b10: result = cap_a ^ cap_b;
            2'b11: result = ~(cap_a & cap_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            winner <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_op <= '0;
            gnt    <= '0;
            done   <= '0;
            y      <= '0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= GRANT;
                        winner <= pick;
                        gnt    <= 4'b0001 << pick;
                        busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    cap_a  <= a_bus[int'(winner)*WIDTH +: WIDTH];
                    cap_b  <= b_bus[int'(winner)*WIDTH +: WIDTH];
                    cap_op <= op_bus[int'(winner)*2 +: 2];
                    gnt    <= '0;
                    state  <= EXEC;
                end
                EXEC: begin
                    y     <= result;
                    done  <= 4'b0001 << winner;
                    state <= DONE;
                end
                DONE: begin
                    done <= '0;
`ifdef LOGIC_ARB_LOCK_EN
                    // Held grant: re-serve the same winner, pointer frozen.
                    if (lock[winner] && req[winner]) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << winner;
                    end else
`endif
                    begin
                        state  <= IDLE;
                        rr_ptr <= winner + 2'd1;
                        busy   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_arb.sv
// Randomized self-checking bench for logic_arb against a transaction model.
// Lock scenario runs only when LOGIC_ARB_LOCK_EN is defined.
module tb_logic_arb;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = '0;
    logic [4*W-1:0] a_bus = '0;
    logic [4*W-1:0] b_bus = '0;
    logic [7:0]     op_bus = '0;
    logic [3:0]     lock = '0;
    logic [3:0]     gnt;
    logic [3:0]     done;
    logic [W-1:0]   y;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int ptr = 0;
    logic [W-1:0] y_ref = '0;

    logic_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus),
        .b_bus(b_bus), .op_bus(op_bus), .lock(lock), .gnt(gnt),
        .done(done), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_excl();
        chk("excl", {31'd0, $onehot0(gnt) && $onehot0(done)
                     && !((|gnt) && (|done))}, 32'd1);
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_op(input logic [1:0] o,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (o)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic randomize_ops();
        a_bus  = {$urandom, $urandom};
        b_bus  = {$urandom, $urandom};
        op_bus = 8'($urandom);
    endtask

    // One full operation; entered and left in an IDLE cycle, #1 past the edge.
    task automatic do_op(input logic [3:0] r, input bit scramble);
        int w;
        logic [W-1:0] exp;
        req = r;
        w = rr_pick(r, ptr);
        exp = ref_op(op_bus[2*w +: 2], a_bus[W*w +: W], b_bus[W*w +: W]);
        @(posedge clk); #1;
        chk("gnt", {28'd0, gnt}, 32'd1 << w);
        chk("busy_grant", {31'd0, busy}, 32'd1);
        chk_excl();
        @(posedge clk); #1;
        if (scramble) begin
            randomize_ops();
            req = r & ~(4'd1 << w);
        end
        chk("exec_quiet", {24'd0, gnt, done}, 32'd0);
        chk("y_hold", {24'd0, y}, {24'd0, y_ref});
        @(posedge clk); #1;
        chk("done", {28'd0, done}, 32'd1 << w);
        chk("y", {24'd0, y}, {24'd0, exp});
        chk_excl();
        ptr = (w + 1) % 4;
        y_ref = exp;
        @(posedge clk); #1;
        chk("idle", {27'd0, busy, gnt}, 32'd0);
        chk("y_after", {24'd0, y}, {24'd0, y_ref});
    endtask

    initial begin
        #2;
        chk("rst_out", {19'd0, busy, gnt, done, y}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_noreq", {27'd0, busy, gnt}, 32'd0);

        // Single request, AND
        a_bus[7:0] = 8'hF0; b_bus[7:0] = 8'h3C; op_bus[1:0] = 2'b00;
        do_op(4'b0001, 1'b0);
        chk("single_y", {24'd0, y}, 32'h30);

        // All ops on requester 2
        for (int o = 0; o < 4; o++) begin
            a_bus[23:16] = 8'hF0; b_bus[23:16] = 8'h3C;
            op_bus[5:4] = 2'(o);
            do_op(4'b0100, 1'b0);
        end
        chk("nand_y", {24'd0, y}, 32'hCF);

        // Contention: rotation from current pointer, then wrap
        for (int i = 0; i < 5; i++) do_op(4'b1111, 1'b0);
        while (ptr != 0) do_op(4'b1111, 1'b0);
        do_op(4'b1000, 1'b0);
        do_op(4'b1001, 1'b0);
        chk("wrap_ptr", ptr, 32'd1);

        // Randomized traffic with late operand/request changes
        for (int i = 0; i < 40; i++) begin
            randomize_ops();
            do_op(4'($urandom_range(1, 15)), 1'($urandom));
        end

        // Reset during EXEC
        req = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {19'd0, busy, gnt, done, y}, 32'd0);
        @(posedge clk); #1;
        chk("rst_nodone", {28'd0, done}, 32'd0);
        rst_n = 1'b1;
        ptr = 0;
        y_ref = '0;
        randomize_ops();
        do_op(4'b1010, 1'b0);
        chk("post_rst_ptr", ptr, 32'd2);

`ifdef LOGIC_ARB_LOCK_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b0011;
        lock = 4'b0001;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            chk("lock_gnt", {28'd0, gnt}, 32'd1);
            @(posedge clk); #1;
            if (n == 2) lock = 4'b0000;
            @(posedge clk); #1;
            chk("lock_done", {28'd0, done}, 32'd1);
            @(posedge clk); #1;
        end
        chk("lock_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("lock_next", {28'd0, gnt}, 32'd2);
        req = '0;
        repeat (4) @(posedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
